// File: rtl/apb_req_arbiter_if.sv
// Request/response bundle between the front-end requesters, the arbiter
// and the shared backend register bank.
interface apb_req_arbiter_if #(
  parameter int unsigned nreq = 4
);
  logic [nreq-1:0]    i_req_valid;
  logic [nreq*32-1:0] i_req_addr;
  logic [nreq-1:0]    i_req_write;
  logic [nreq*32-1:0] i_req_wdata;
  logic [nreq-1:0]    o_resp_valid;
  logic [31:0]        o_resp_rdata;
  logic               o_resp_err;
  logic               o_req_valid;
  logic [31:0]        o_req_addr;
  logic               o_req_write;
  logic [31:0]        o_req_wdata;
  logic               i_resp_valid;
  logic [31:0]        i_resp_rdata;
  logic               i_resp_err;
  logic               o_busy;
  logic               o_timeout;

  // Arbiter side.
  modport slave (
    input  i_req_valid, i_req_addr, i_req_write, i_req_wdata,
    input  i_resp_valid, i_resp_rdata, i_resp_err,
    output o_resp_valid, o_resp_rdata, o_resp_err,
    output o_req_valid, o_req_addr, o_req_write, o_req_wdata,
    output o_busy, o_timeout
  );

  // Environment side (requesters plus backend).
  modport master (
    output i_req_valid, i_req_addr, i_req_write, i_req_wdata,
    output i_resp_valid, i_resp_rdata, i_resp_err,
    input  o_resp_valid, o_resp_rdata, o_resp_err,
    input  o_req_valid, o_req_addr, o_req_write, o_req_wdata,
    input  o_busy, o_timeout
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: shares one backend request/response channel between nreq
// one-shot requesters. Requests are latched into per-port slots, served one
// at a time in round-robin order, and each response is routed back to its
// owner; a silent backend produces a forced error response.
module apb_req_arbiter #(
  parameter int unsigned nreq           = 4,
  parameter int unsigned timeout_cycles = 255
) (
  input  logic             i_clk,
  input  logic             i_rst,
  apb_req_arbiter_if.slave bus
);

  localparam int unsigned GW = (nreq > 1) ? $clog2(nreq) : 1;
  localparam int unsigned CW = (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_LAST = (timeout_cycles > 0) ? CW'(timeout_cycles - 1) : '0;

  typedef enum logic {IDLE, WAIT_RESP} state_t;

  state_t          state, state_next;
  logic [nreq-1:0] pend;
  logic [31:0]     slot_addr  [nreq];
  logic [31:0]     slot_wdata [nreq];
  logic [nreq-1:0] slot_write;
  logic [GW-1:0]   grant, last_grant, pick, idx;
  logic            pick_found;
  logic [CW-1:0]   cnt;
  logic            resp_hit, timeout_hit, release_en;

  logic            req_valid_d, req_write_d, resp_err_d, timeout_d;
  logic [31:0]     req_addr_d, req_wdata_d, resp_rdata_d;
  logic [nreq-1:0] resp_valid_d;

  assign resp_hit    = (state == WAIT_RESP) && bus.i_resp_valid;
  assign timeout_hit = (state == WAIT_RESP) && !bus.i_resp_valid &&
                       (timeout_cycles != 0) && (cnt == CNT_LAST);
  assign release_en  = resp_hit || timeout_hit;
  assign bus.o_busy  = (state == WAIT_RESP);

  // Round-robin search: first pending port after the last one served.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    idx        = '0;
    for (int unsigned i = 1; i <= nreq; i++) begin
      idx = GW'((32'(last_grant) + i) % nreq);
      if (!pick_found && pend[idx]) begin
        pick       = idx;
        pick_found = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state: grant when anything is pending, return on response or timeout.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (pick_found) state_next = WAIT_RESP;
      WAIT_RESP: if (release_en) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Output decode: next values of the registered outputs; fields hold otherwise.
  always_comb begin
    req_valid_d  = 1'b0;
    req_addr_d   = bus.o_req_addr;
    req_write_d  = bus.o_req_write;
    req_wdata_d  = bus.o_req_wdata;
    resp_valid_d = '0;
    resp_rdata_d = bus.o_resp_rdata;
    resp_err_d   = bus.o_resp_err;
    timeout_d    = 1'b0;
    if (state == IDLE && pick_found) begin
      req_valid_d = 1'b1;
      req_addr_d  = slot_addr[pick];
      req_write_d = slot_write[pick];
      req_wdata_d = slot_wdata[pick];
    end
    if (release_en) begin
      resp_valid_d[grant] = 1'b1;
      resp_rdata_d        = resp_hit ? bus.i_resp_rdata : '0;
      resp_err_d          = resp_hit ? bus.i_resp_err : 1'b1;
      timeout_d           = timeout_hit;
    end
  end

  // Slots, grant bookkeeping, timeout counter and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pend             <= '0;
      grant            <= '0;
      last_grant       <= GW'(nreq - 1);
      cnt              <= '0;
      bus.o_req_valid  <= 1'b0;
      bus.o_req_addr   <= '0;
      bus.o_req_write  <= 1'b0;
      bus.o_req_wdata  <= '0;
      bus.o_resp_valid <= '0;
      bus.o_resp_rdata <= '0;
      bus.o_resp_err   <= 1'b0;
      bus.o_timeout    <= 1'b0;
    end else begin
      // A slot being released this cycle can accept its owner's next request.
      for (int unsigned k = 0; k < nreq; k++) begin
        if (bus.i_req_valid[k] && (!pend[k] || (release_en && grant == GW'(k)))) begin
          pend[k]       <= 1'b1;
          slot_addr[k]  <= bus.i_req_addr[32*k +: 32];
          slot_write[k] <= bus.i_req_write[k];
          slot_wdata[k] <= bus.i_req_wdata[32*k +: 32];
        end else if (release_en && grant == GW'(k)) begin
          pend[k] <= 1'b0;
        end
      end
      if (state == IDLE && pick_found) begin
        grant <= pick;
        cnt   <= '0;
      end else if (state == WAIT_RESP && cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
      if (release_en) last_grant <= grant;
      bus.o_req_valid  <= req_valid_d;
      bus.o_req_addr   <= req_addr_d;
      bus.o_req_write  <= req_write_d;
      bus.o_req_wdata  <= req_wdata_d;
      bus.o_resp_valid <= resp_valid_d;
      bus.o_resp_rdata <= resp_rdata_d;
      bus.o_resp_err   <= resp_err_d;
      bus.o_timeout    <= timeout_d;
    end
  end

endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Shares one register-bank backend request/response channel between nreq APB slave front-ends.
- Each front-end presents a one-cycle request pulse with no backpressure. It then waits for its response.
- The block latches pending requests and serves them one at a time, round-robin. It routes each response back to its owner and raises an error response on backend timeout.
- It sits between the per-peripheral APB slave adapters and a shared register file/CSR bank.

Parameters:
- nreq, 4, number of requester ports (2..8).
- timeout_cycles, 255, WaitResp cycles before forced error response; 0 disables timeout.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset, synchronous, active-high
- i_req_valid  in  nreq  per-port one-cycle request pulse
- i_req_addr  in  nreq*32  per-port address, port k at bits [32k+31:32k]
- i_req_write  in  nreq  per-port write flag
- i_req_wdata  in  nreq*32  per-port write data, same packing as i_req_addr
- o_resp_valid  out  nreq  one-hot, one-cycle response strobe to owning port
- o_resp_rdata  out  32  response read data, shared bus
- o_resp_err  out  1  response error, shared bus
- o_req_valid  out  1  backend one-cycle request pulse
- o_req_addr  out  32  backend address
- o_req_write  out  1  backend write flag
- o_req_wdata  out  32  backend write data
- i_resp_valid  in  1  backend response strobe
- i_resp_rdata  in  32  backend read data
- i_resp_err  in  1  backend error
- o_busy  out  1  transaction outstanding (state WaitResp)
- o_timeout  out  1  one-cycle pulse when a timeout response is generated

Behaviour:
- One clock; i_rst synchronous, active-high. It takes effect on the next i_clk edge, in any state.
- Reset values:
  - All outputs 0.
  - All pend[k]=0; state=Idle; timeout counter=0.
  - last_grant=nreq-1, so port 0 has first priority.
- Capture:
  - Each port has a pending slot: pend, addr, write, wdata.
  - If i_req_valid[k]=1 and pend[k]=0, the slot is loaded and pend[k]=1 on the next edge.
  - If pend[k]=1 and the slot is not being released this cycle, the request is dropped silently (protocol violation).
  - If port k's slot is released in the same cycle that i_req_valid[k]=1, the new request is captured and pend[k] stays 1.
- State machine, Idle:
  - If any pend=1, grant the first pending port searching from (last_grant+1) mod nreq upward with wrap.
  - Register o_req_valid=1 with the granted slot fields; store grant; clear the counter; go to WaitResp.
  - If no pend is set, stay in Idle.
- State machine, WaitResp:
  - o_req_valid=0 (single pulse). o_req_addr/write/wdata hold their values until the next grant.
  - o_busy=1. The counter increments every cycle.
  - If i_resp_valid=1:
    - Next cycle: o_resp_valid[grant]=1, o_resp_rdata=i_resp_rdata, o_resp_err=i_resp_err.
    - Release pend[grant]; last_grant=grant; go to Idle.
  - Timeout: if timeout_cycles!=0, the counter equals timeout_cycles-1, and i_resp_valid=0:
    - Next cycle: o_resp_valid[grant]=1, rdata=0, err=1, o_timeout=1.
    - Release and go to Idle as for a normal response.
  - If the backend response and the timeout occur in the same cycle, the backend response wins and o_timeout=0.
- Stray responses: i_resp_valid in Idle is ignored, with no output change.
- o_resp_valid is 0 in every cycle except a single response cycle.
- o_resp_rdata and o_resp_err hold their last values between responses.
- Latency:
  - Request pulse in cycle N on an idle block gives o_req_valid in cycle N+2.
  - Backend response in cycle M gives o_resp_valid in cycle M+1.
  - At least one Idle cycle separates consecutive grants.
- Counter width is clog2(timeout_cycles+1), minimum 1. It saturates and never wraps.

Test Plan:
- Single request: port 1 pulse at cycle 0 (addr 0x10, read), backend responds rdata 0xCAFE0001 three cycles after o_req_valid.
  - Required: o_req_valid at cycle 2 with addr 0x10.
  - Required: o_resp_valid=4'b0010, rdata 0xCAFE0001, err=0.
- Contention: all 4 ports pulse in the same cycle, backend latency 1.
  - Required: grant order 0,1,2,3, each response one-hot to its own port.
  - Then ports 0 and 2 pulse together: required order 2,0? No — after last_grant=3 the search starts at 0, so required order 0,2.
- Timeout: timeout_cycles=8, port 3 write, no backend response.
  - Required: 8 cycles after o_req_valid, o_resp_valid=4'b1000, rdata 0, err=1, o_timeout=1.
  - Then the next pending port is served.
- Simultaneous timeout and response at the timeout cycle with rdata 0x55.
  - Required: rdata 0x55, err=i_resp_err, o_timeout=0.
- Duplicate and stray events:
  - Port 0 pulses again while pending: dropped, exactly one backend transaction.
  - i_resp_valid in Idle: no o_resp_valid.
  - Port k re-request in its release cycle: captured and served.
- Reset mid-operation: assert i_rst in WaitResp with 2 pending slots.
  - Required: next cycle all outputs 0, no later response or request.
  - A port 0 request after reset is served first.
